spike_rate_monitor: RTL and testbench
=====================================

// Module: spike_rate_monitor
// PURPOSE
//   Consumes the 8-bit membrane potential V_mem produced by the decoder neuron stage.
//   Detects threshold crossings with hysteresis and emits a one-cycle spike pulse.
//   Enforces a refractory period after each spike.
//   Counts spikes over a fixed window and publishes the latched rate for the display/uio path.
// PARAMETERS
//   DATA_W     8     width of V_mem
//   THRESH     200   fire threshold; a spike needs V_mem >= THRESH
//   HYST       20    re-arm hysteresis; re-arm needs V_mem < THRESH-HYST. Constraint: HYST <= THRESH
//   REFRAC_CYC 10    refractory length in clk cycles; 0 = none
//   WIN_CYC    1000  rate window length in enabled clk cycles; must be >= 2
//   CNT_W      8     width of the rate counter; saturates at 2^CNT_W-1
// PORTS
//   clk         in   1       system clock; all logic on the rising edge
//   rst_n       in   1       asynchronous, active-HIGH reset (name matches the decoder port)
//   en          in   1       enable for spike detection and the window counter
//   V_mem       in   DATA_W  membrane potential, unsigned, sampled every clk
//   spike       out  1       one-cycle pulse per detected spike
//   refractory  out  1       high while in the REFRAC state
//   rate        out  CNT_W   spike count of the last completed window
//   rate_valid  out  1       one-cycle pulse when rate updates
// BEHAVIOUR
//   Reset (async assert, sync release): state=ARMED; spike=0, refractory=0, rate=0, rate_valid=0.
//     Reset also clears all internal counters.
//     Reset asserted mid-REFRAC/REARM/window aborts immediately; no pending pulse is emitted.
//   Fire condition F (evaluated at each edge): state==ARMED && en && V_mem>=THRESH.
//   FSM (registered; spike and refractory are registered outputs):
//     ARMED  -> on F: spike<=1 for exactly one cycle, rcnt<=REFRAC_CYC.
//               Next state is REFRAC, or REARM if REFRAC_CYC==0.
//     REFRAC -> refractory=1; rcnt decrements each edge regardless of en.
//               When rcnt==1, next state is REARM.
//               refractory is high for exactly REFRAC_CYC cycles.
//     REARM  -> when V_mem < THRESH-HYST, next state is ARMED.
//               The low bound is computed in DATA_W+1 bits and is never negative.
//               Holding V_mem >= THRESH never produces a second spike.
//   Spike latency: V_mem sampled >= THRESH at edge k -> spike high in cycle k..k+1.
//   en=0: F is false and the window counter holds. REFRAC and REARM still advance.
//   Window: wcnt counts 0..WIN_CYC-1 on enabled cycles; scnt increments on each F and saturates.
//     At the edge where wcnt==WIN_CYC-1 (enabled):
//       rate <= scnt + (F ? 1 : 0), saturated.
//       rate_valid <= 1 for one cycle; scnt <= 0; wcnt <= 0.
//     A spike on the closing edge counts into the closing window, not the next one.
//   All arithmetic is unsigned; no wrap on rate or scnt (clamp at 2^CNT_W-1).
// TESTING
//   1 Reset with V_mem=255 -> spike=0, refractory=0, rate=0, rate_valid=0; no spike until rst_n drops.
//   2 Ramp V_mem +1/cycle from 0 -> a single spike pulse the cycle after 200 is sampled.
//     refractory then stays high for exactly 10 cycles.
//   3 Hold V_mem=255 for 100 cycles -> exactly 1 spike.
//     Drop to 179, then 200 -> second spike. Drop only to 180, then 200 -> no spike.
//   4 Produce 7 spikes in a 1000-cycle window, the 7th on the closing edge
//     -> rate=7, rate_valid one pulse; next window starts at scnt=0.
//   5 REFRAC_CYC=0, WIN_CYC=1000, V_mem alternating 255/0 per cycle -> more than 255 spikes -> rate=255.
//   6 en=0 for 50 cycles mid-window -> no spikes; rate_valid is delayed by exactly 50 cycles.
//     Assert rst_n mid-REFRAC -> outputs cleared immediately (asynchronously).

Source files
------------

// File: rtl/spike_rate_monitor.sv
// Threshold-crossing spike detector with hysteresis re-arm, refractory hold-off
// and a windowed, saturating spike-rate counter.
module spike_rate_monitor #(
  parameter int DATA_W     = 8,
  parameter int THRESH     = 200,
  parameter int HYST       = 20,
  parameter int REFRAC_CYC = 10,
  parameter int WIN_CYC    = 1000,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] V_mem,
  output logic              spike,
  output logic              refractory,
  output logic [CNT_W-1:0]  rate,
  output logic              rate_valid
);

  localparam int RC_W = (REFRAC_CYC > 1) ? $clog2(REFRAC_CYC + 1) : 1;
  localparam int WC_W = $clog2(WIN_CYC);

  // Both levels live in DATA_W+1 bits so THRESH-HYST can never go negative.
  localparam logic [DATA_W:0]  FIRE_LVL = (DATA_W + 1)'(THRESH);
  localparam logic [DATA_W:0]  LOW_LVL  = (DATA_W + 1)'(THRESH - HYST);
  localparam logic [RC_W-1:0]  RC_INIT  = RC_W'(REFRAC_CYC);
  localparam logic [WC_W-1:0]  WIN_LAST = WC_W'(WIN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    REFRAC = 2'd1,
    REARM  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [RC_W-1:0]  rcnt_q, rcnt_d;
  logic             spike_q, spike_d;
  logic             refractory_q, refractory_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic [CNT_W-1:0] rate_q, rate_d;
  logic             rate_valid_q, rate_valid_d;

  logic             fire;
  logic             rearm_ok;
  logic [CNT_W-1:0] scnt_next;

  assign fire     = (state_q == ARMED) && en && ({1'b0, V_mem} >= FIRE_LVL);
  assign rearm_ok = {1'b0, V_mem} < LOW_LVL;

  always_comb begin
    state_d      = state_q;
    rcnt_d       = rcnt_q;
    spike_d      = 1'b0;
    refractory_d = 1'b0;
    case (state_q)
      ARMED: begin
        if (fire) begin
          spike_d = 1'b1;
          rcnt_d  = RC_INIT;
          state_d = (REFRAC_CYC == 0) ? REARM : REFRAC;
        end
      end
      REFRAC: begin
        rcnt_d = rcnt_q - RC_W'(1);
        if (rcnt_q == RC_W'(1)) begin
          state_d = REARM;
        end
      end
      REARM: begin
        if (rearm_ok) begin
          state_d = ARMED;
        end
      end
      default: state_d = ARMED;
    endcase
    refractory_d = (state_d == REFRAC);
  end

  // A spike on the closing edge is folded into the rate being published.
  always_comb begin
    wcnt_d       = wcnt_q;
    scnt_d       = scnt_q;
    rate_d       = rate_q;
    rate_valid_d = 1'b0;
    scnt_next    = scnt_q;
    if (fire && (scnt_q != CNT_MAX)) begin
      scnt_next = scnt_q + CNT_W'(1);
    end
    if (en) begin
      if (wcnt_q == WIN_LAST) begin
        rate_d       = scnt_next;
        rate_valid_d = 1'b1;
        scnt_d       = '0;
        wcnt_d       = '0;
      end else begin
        wcnt_d = wcnt_q + WC_W'(1);
        scnt_d = scnt_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= ARMED;
      rcnt_q       <= '0;
      spike_q      <= 1'b0;
      refractory_q <= 1'b0;
      wcnt_q       <= '0;
      scnt_q       <= '0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rcnt_q       <= rcnt_d;
      spike_q      <= spike_d;
      refractory_q <= refractory_d;
      wcnt_q       <= wcnt_d;
      scnt_q       <= scnt_d;
      rate_q       <= rate_d;
      rate_valid_q <= rate_valid_d;
    end
  end

  assign spike      = spike_q;
  assign refractory = refractory_q;
  assign rate       = rate_q;
  assign rate_valid = rate_valid_q;

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Directed bench for spike_rate_monitor: default instance plus a
// zero-refractory instance used for the rate saturation scenario.
module tb_spike_rate_monitor;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] V_mem;
  logic       spike;
  logic       refractory;
  logic [7:0] rate;
  logic       rate_valid;

  logic       en_b;
  logic [7:0] v_b;
  logic       spike_b;
  logic       refractory_b;
  logic [7:0] rate_b;
  logic       rate_valid_b;

  int n_checks;
  int n_fail;

  spike_rate_monitor dut (
    .clk        (clk),
    .rst_n      (rst),
    .en         (en),
    .V_mem      (V_mem),
    .spike      (spike),
    .refractory (refractory),
    .rate       (rate),
    .rate_valid (rate_valid)
  );

  spike_rate_monitor #(.REFRAC_CYC(0), .WIN_CYC(1000)) dut_b (
    .clk        (clk),
    .rst_n      (rst),
    .en         (en_b),
    .V_mem      (v_b),
    .spike      (spike_b),
    .refractory (refractory_b),
    .rate       (rate_b),
    .rate_valid (rate_valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // After this returns, the next rising edge is edge 1 of a fresh window.
  task automatic do_reset;
    rst   = 1'b1;
    en    = 1'b1;
    V_mem = 8'd0;
    en_b  = 1'b0;
    v_b   = 8'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    en    = 1'b1;
    V_mem = 8'd255;
    en_b  = 1'b0;
    v_b   = 8'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (spike !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_spike: got %b want 0", spike);
      end
      n_checks++;
      if (refractory !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_refractory: got %b want 0", refractory);
      end
      n_checks++;
      if (rate !== 8'd0) begin
        n_fail++;
        $display("[TB] FAIL reset_rate: got %0d want 0", rate);
      end
      n_checks++;
      if (rate_valid !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_rate_valid: got %b want 0", rate_valid);
      end
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (spike !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_release_spike: got %b want 1", spike);
    end
  endtask

  task automatic test_ramp;
    int spikes;
    logic exp_spike;
    logic exp_ref;
    spikes = 0;
    do_reset();
    for (int v = 0; v <= 230; v++) begin
      V_mem = 8'(v);
      tick();
      exp_spike = (v == 200);
      exp_ref   = (v >= 200) && (v <= 209);
      if (spike === 1'b1) spikes++;
      n_checks++;
      if (spike !== exp_spike) begin
        n_fail++;
        $display("[TB] FAIL ramp_spike v=%0d: got %b want %b", v, spike, exp_spike);
      end
      n_checks++;
      if (refractory !== exp_ref) begin
        n_fail++;
        $display("[TB] FAIL ramp_refractory v=%0d: got %b want %b", v, refractory, exp_ref);
      end
    end
    n_checks++;
    if (spikes != 1) begin
      n_fail++;
      $display("[TB] FAIL ramp_spike_count: got %0d want 1", spikes);
    end
  endtask

  task automatic test_hysteresis;
    int spikes;
    do_reset();
    spikes = 0;
    V_mem  = 8'd255;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (spike === 1'b1) spikes++;
    end
    n_checks++;
    if (spikes != 1) begin
      n_fail++;
      $display("[TB] FAIL hold_255_spikes: got %0d want 1", spikes);
    end

    spikes = 0;
    V_mem  = 8'd179;
    tick();
    if (spike === 1'b1) spikes++;
    V_mem = 8'd200;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (spike === 1'b1) spikes++;
    end
    n_checks++;
    if (spikes != 1) begin
      n_fail++;
      $display("[TB] FAIL rearm_179_spikes: got %0d want 1", spikes);
    end

    spikes = 0;
    V_mem  = 8'd180;
    tick();
    if (spike === 1'b1) spikes++;
    V_mem = 8'd200;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (spike === 1'b1) spikes++;
    end
    n_checks++;
    if (spikes != 0) begin
      n_fail++;
      $display("[TB] FAIL no_rearm_180_spikes: got %0d want 0", spikes);
    end
  endtask

  task automatic test_window;
    logic is_spk;
    logic exp_rv;
    do_reset();
    for (int n = 1; n <= 2000; n++) begin
      is_spk = ((n % 100 == 0) && (n <= 600)) || (n == 1000) || (n == 1100);
      V_mem  = is_spk ? 8'd255 : 8'd0;
      tick();
      exp_rv = (n == 1000) || (n == 2000);
      n_checks++;
      if (spike !== is_spk) begin
        n_fail++;
        $display("[TB] FAIL window_spike n=%0d: got %b want %b", n, spike, is_spk);
      end
      n_checks++;
      if (rate_valid !== exp_rv) begin
        n_fail++;
        $display("[TB] FAIL window_rate_valid n=%0d: got %b want %b", n, rate_valid, exp_rv);
      end
      if (n == 1000 || n == 1001) begin
        n_checks++;
        if (rate !== 8'd7) begin
          n_fail++;
          $display("[TB] FAIL window1_rate n=%0d: got %0d want 7", n, rate);
        end
      end
      if (n == 2000) begin
        n_checks++;
        if (rate !== 8'd1) begin
          n_fail++;
          $display("[TB] FAIL window2_rate: got %0d want 1", rate);
        end
      end
    end
  endtask

  task automatic test_saturation;
    logic odd;
    do_reset();
    en_b = 1'b1;
    for (int n = 1; n <= 1000; n++) begin
      odd = (n % 2 == 1);
      v_b = odd ? 8'd255 : 8'd0;
      tick();
      n_checks++;
      if (spike_b !== odd) begin
        n_fail++;
        $display("[TB] FAIL sat_spike n=%0d: got %b want %b", n, spike_b, odd);
      end
      n_checks++;
      if (refractory_b !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL sat_refractory n=%0d: got %b want 0", n, refractory_b);
      end
      n_checks++;
      if (rate_valid_b !== (n == 1000)) begin
        n_fail++;
        $display("[TB] FAIL sat_rate_valid n=%0d: got %b want %b", n, rate_valid_b, (n == 1000));
      end
    end
    n_checks++;
    if (rate_b !== 8'd255) begin
      n_fail++;
      $display("[TB] FAIL sat_rate: got %0d want 255", rate_b);
    end
    en_b = 1'b0;
  endtask

  task automatic test_enable_and_abort;
    logic gated;
    logic exp_spk;
    do_reset();
    for (int n = 1; n <= 1050; n++) begin
      gated   = (n >= 301) && (n <= 350);
      en      = !gated;
      exp_spk = (n == 100) || (n == 295);
      V_mem   = (exp_spk || gated) ? 8'd255 : 8'd0;
      tick();
      n_checks++;
      if (spike !== exp_spk) begin
        n_fail++;
        $display("[TB] FAIL en_spike n=%0d: got %b want %b", n, spike, exp_spk);
      end
      n_checks++;
      if (rate_valid !== (n == 1050)) begin
        n_fail++;
        $display("[TB] FAIL en_rate_valid n=%0d: got %b want %b", n, rate_valid, (n == 1050));
      end
      if (n == 300) begin
        n_checks++;
        if (refractory !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL en_refrac_before_gate: got %b want 1", refractory);
        end
      end
      if (n == 310) begin
        n_checks++;
        if (refractory !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL en_refrac_runs_gated: got %b want 0", refractory);
        end
      end
    end
    n_checks++;
    if (rate !== 8'd2) begin
      n_fail++;
      $display("[TB] FAIL en_rate: got %0d want 2", rate);
    end

    en    = 1'b1;
    V_mem = 8'd255;
    tick();
    n_checks++;
    if (spike !== 1'b1 || refractory !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL abort_setup: got spike=%b refr=%b want 1 1", spike, refractory);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (spike !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_spike: got %b want 0", spike);
    end
    n_checks++;
    if (refractory !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_refractory: got %b want 0", refractory);
    end
    n_checks++;
    if (rate !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL abort_rate: got %0d want 0", rate);
    end
    n_checks++;
    if (rate_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_rate_valid: got %b want 0", rate_valid);
    end
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_ramp();
    test_hysteresis();
    test_window();
    test_saturation();
    test_enable_and_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
